// File: rtl/vga_pkg.sv
// Shared VGA timing constants and elaboration helpers.
// Holds the default 640x480@60 porch/sync figures, the total-period
// function used for H_TOTAL/V_TOTAL, and a ceil-log2 helper for
// sizing and checking counter widths.
package vga_pkg;

    // Default 640x480@60 horizontal timing (pixels)
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;

    // Default 640x480@60 vertical timing (lines)
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    // Pixel clock divider limits; DIV_W holds 0..CLK_DIV_MAX-1
    localparam int unsigned CLK_DIV_MAX  = 16;
    localparam int unsigned DIV_W        = 4;

    // Full period of one axis: visible + front porch + sync + back porch
    function automatic int unsigned vga_total(input int unsigned active,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // Smallest r with 2**r >= n, i.e. bits needed to count 0..n-1
    function automatic int unsigned vga_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((33'd1 << i) < 33'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pix_ce_div.sv
// Pixel clock-enable divider.
// Ports:
//   clk, rst_n  board clock, synchronous active-low reset
//   en_i        run enable; low freezes the divider
//   step_c      combinational: raster advances at this clk edge
//   pix_ce_o    registered one-clk pulse per pixel, forced low while frozen
module pix_ce_div
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic step_c,
    output logic pix_ce_o
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             pix_ce_q, pix_ce_d;

    // tick_q marks a pending pixel step; it is held across en=0 so a pause
    // never drops or inserts a pixel.
    always_comb begin
        div_d    = div_q;
        tick_d   = tick_q;
        pix_ce_d = 1'b0;
        if (en_i) begin
            div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
            tick_d   = (div_q == DIV_LAST);
            pix_ce_d = (div_q == DIV_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q    <= '0;
            tick_q   <= 1'b0;
            pix_ce_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            tick_q   <= tick_d;
            pix_ce_q <= pix_ce_d;
        end
    end

    assign step_c   = en_i & tick_q;
    assign pix_ce_o = pix_ce_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
// Ports:
//   clk, rst_n  board clock, synchronous active-low reset
//   en          run enable; low freezes all state
//   pix_ce      one-clk pulse per pixel
//   x, y        raster position, 0..H_TOTAL-1 / 0..V_TOTAL-1
//   de          inside the active area
//   hsync/vsync sync strobes with configurable polarity
//   sof, eol    start-of-frame / end-of-line pulses
//   frame_cnt   completed frames, wrapping
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter int unsigned CLK_DIV  = 2,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned CNT_W    = 11,
    parameter int unsigned FC_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             pix_ce,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic             sof,
    output logic             eol,
    output logic [FC_W-1:0]  frame_cnt
);

    localparam int unsigned H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] X_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] Y_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Reject configurations the counters or divider cannot represent
    if (CNT_W < vga_clog2(H_TOTAL) || CNT_W < vga_clog2(V_TOTAL)) begin : g_bad_cnt_w
        $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
    end
    if (CLK_DIV == 0 || CLK_DIV > CLK_DIV_MAX) begin : g_bad_clk_div
        $error("vga_timing_gen: CLK_DIV outside 1..16");
    end

    logic             step_c;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic [FC_W-1:0]  fc_q, fc_d;
    logic             de_q, de_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             sof_q, sof_d;
    logic             eol_q, eol_d;

    pix_ce_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (en),
        .step_c   (step_c),
        .pix_ce_o (pix_ce)
    );

    // Raster advance; every decoded output is taken from the next position
    // so all of them change in the same clk as x/y.
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        fc_d  = fc_q;
        de_d  = de_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        sof_d = 1'b0;
        eol_d = 1'b0;
        if (step_c) begin
            if (x_q == X_LAST) begin
                x_d   = '0;
                eol_d = 1'b1;
                if (y_q == Y_LAST) begin
                    y_d   = '0;
                    sof_d = 1'b1;
                    fc_d  = fc_q + FC_W'(1);
                end else begin
                    y_d = y_q + CNT_W'(1);
                end
            end else begin
                x_d = x_q + CNT_W'(1);
            end
            de_d = (x_d < X_ACT) && (y_d < Y_ACT);
            hs_d = ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) ? HS_POL : ~HS_POL;
            vs_d = ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) ? VS_POL : ~VS_POL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            fc_q  <= '0;
            de_q  <= 1'b1;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            sof_q <= 1'b0;
            eol_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            fc_q  <= fc_d;
            de_q  <= de_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            sof_q <= sof_d;
            eol_q <= eol_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign frame_cnt = fc_q;
    assign de        = de_q;
    assign hsync     = hs_q;
    assign vsync     = vs_q;
    assign sof       = sof_q;
    assign eol       = eol_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 line timing, a tiny
// CLK_DIV=1 raster with positive syncs, and a CLK_DIV=3 raster with a 2-bit
// frame counter, en pause and mid-frame reset.
module tb_vga_timing_gen;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instance A: defaults (800x525, CLK_DIV=2, negative syncs)
    logic        rst_a, en_a, pix_ce_a, de_a, hs_a, vs_a, sof_a, eol_a;
    logic [10:0] x_a, y_a;
    logic [15:0] fc_a;

    vga_timing_gen u_a (
        .clk(clk), .rst_n(rst_a), .en(en_a), .pix_ce(pix_ce_a),
        .x(x_a), .y(y_a), .de(de_a), .hsync(hs_a), .vsync(vs_a),
        .sof(sof_a), .eol(eol_a), .frame_cnt(fc_a)
    );

    // Instance B: 14x7 raster, CLK_DIV=1, positive syncs
    logic        rst_b, en_b, pix_ce_b, de_b, hs_b, vs_b, sof_b, eol_b;
    logic [3:0]  x_b, y_b;
    logic [15:0] fc_b;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4), .FC_W(16)
    ) u_b (
        .clk(clk), .rst_n(rst_b), .en(en_b), .pix_ce(pix_ce_b),
        .x(x_b), .y(y_b), .de(de_b), .hsync(hs_b), .vsync(vs_b),
        .sof(sof_b), .eol(eol_b), .frame_cnt(fc_b)
    );

    // Instance C: 14x7 raster, CLK_DIV=3, 2-bit frame counter
    logic        rst_c, en_c, pix_ce_c, de_c, hs_c, vs_c, sof_c, eol_c;
    logic [3:0]  x_c, y_c;
    logic [1:0]  fc_c;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(3), .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(4), .FC_W(2)
    ) u_c (
        .clk(clk), .rst_n(rst_c), .en(en_c), .pix_ce(pix_ce_c),
        .x(x_c), .y(y_c), .de(de_c), .hsync(hs_c), .vsync(vs_c),
        .sof(sof_c), .eol(eol_c), .frame_cnt(fc_c)
    );

    // Expected frame_cnt and sof-to-sof spacing at successive sofs of C
    int fc_exp  [5] = '{1, 2, 3, 0, 1};
    int gap_exp [5] = '{295, 294, 1294, 294, 294};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ea, len, hs_lo, de_n, ce_n, dece;
        int sof_n, s1, s2, hs_n, hs_bad, vs_n, vs_bad, eol_n, eol_bad, eol_prev;
        int c, sofc, prev, fz_bad;
        bit frz_done;
        logic [3:0] sx, sy;
        logic shs, svs;

        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        en_a  = 1'b1; en_b  = 1'b1; en_c  = 1'b1;
        tick();
        tick();

        // Reset values
        chk("a_rst_x",      32'(x_a), 0);
        chk("a_rst_y",      32'(y_a), 0);
        chk("a_rst_fc",     32'(fc_a), 0);
        chk("a_rst_de",     32'(de_a), 1);
        chk("a_rst_hsync",  32'(hs_a), 1);
        chk("a_rst_vsync",  32'(vs_a), 1);
        chk("a_rst_pix_ce", 32'(pix_ce_a), 0);
        chk("a_rst_sof",    32'(sof_a), 0);
        chk("a_rst_eol",    32'(eol_a), 0);
        chk("b_rst_hsync",  32'(hs_b), 0);
        chk("b_rst_vsync",  32'(vs_b), 0);
        chk("b_rst_de",     32'(de_b), 1);

        // A: first pixel strobe and advance after reset release
        rst_a = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!pix_ce_a && n < 10);
        chk("a_first_ce_clk", n, 2);
        chk("a_x_during_ce", 32'(x_a), 0);
        tick();
        ea = n + 1;
        chk("a_x_after_ce", 32'(x_a), 1);
        chk("a_ce_after", 32'(pix_ce_a), 0);

        // A: first line wrap after 800 pixels
        while (!eol_a && ea < 2000) begin
            tick();
            ea++;
        end
        chk("a_eol1_clk", ea, 1601);
        chk("a_eol1_x", 32'(x_a), 0);
        chk("a_eol1_y", 32'(y_a), 1);
        chk("a_eol1_sof", 32'(sof_a), 0);

        // A: measure one complete line
        len = 0; hs_lo = 0; de_n = 0; ce_n = 0; dece = 0;
        do begin
            len++;
            if (!hs_a) hs_lo++;
            if (de_a) de_n++;
            if (pix_ce_a) ce_n++;
            if (de_a && pix_ce_a) dece++;
            tick();
        end while (!eol_a && len < 2000);
        chk("a_line_clks", len, 1600);
        chk("a_hsync_low_clks", hs_lo, 192);
        chk("a_de_clks", de_n, 1280);
        chk("a_pix_ce_per_line", ce_n, 800);
        chk("a_de_pix_ce_per_line", dece, 640);
        chk("a_eol2_y", 32'(y_a), 2);
        chk("a_vsync_line2", 32'(vs_a), 1);
        en_a = 1'b0;

        // B: tiny raster, one full frame between first two sofs
        rst_b = 1'b1;
        sof_n = 0; s1 = 0; s2 = 0; hs_n = 0; hs_bad = 0; vs_n = 0; vs_bad = 0;
        de_n = 0; eol_n = 0; eol_bad = 0; eol_prev = 0;
        for (int cy = 1; cy <= 250; cy++) begin
            tick();
            if (sof_b) begin
                sof_n++;
                if (sof_n == 1) begin
                    s1 = cy;
                    chk("b_sof1_x", 32'(x_b), 0);
                    chk("b_sof1_y", 32'(y_b), 0);
                    chk("b_sof1_de", 32'(de_b), 1);
                    chk("b_sof1_eol", 32'(eol_b), 1);
                    chk("b_sof1_fc", 32'(fc_b), 1);
                end else if (sof_n == 2) begin
                    s2 = cy;
                    chk("b_sof2_fc", 32'(fc_b), 2);
                end
            end
            if (sof_n == 1) begin
                if (de_b) de_n++;
                if (hs_b) begin
                    hs_n++;
                    if (x_b != 4'd10 && x_b != 4'd11) hs_bad++;
                end
                if (vs_b) begin
                    vs_n++;
                    if (y_b != 4'd5) vs_bad++;
                end
                if (eol_b) begin
                    eol_n++;
                    if (cy - eol_prev != 14) eol_bad++;
                end
            end
            if (eol_b) eol_prev = cy;
        end
        chk("b_first_sof_clk", s1, 99);
        chk("b_frame_clks", s2 - s1, 98);
        chk("b_de_per_frame", de_n, 32);
        chk("b_hsync_high_clks", hs_n, 14);
        chk("b_hsync_outside_x10_11", hs_bad, 0);
        chk("b_vsync_high_clks", vs_n, 14);
        chk("b_vsync_outside_y5", vs_bad, 0);
        chk("b_lines_per_frame", eol_n, 7);
        chk("b_line_not_14_clks", eol_bad, 0);

        // C: five frames, frame counter wrap, 1000-clk pause in frame 2
        rst_c = 1'b1;
        c = 0; sofc = 0; prev = 0; frz_done = 1'b0;
        while (sofc < 5 && c < 4000) begin
            tick();
            c++;
            if (sof_c) begin
                sofc++;
                chk($sformatf("c_fc_at_sof%0d", sofc), 32'(fc_c), fc_exp[sofc-1]);
                chk($sformatf("c_gap_to_sof%0d", sofc), c - prev, gap_exp[sofc-1]);
                prev = c;
            end
            if (sofc == 2 && !frz_done && c == prev + 20) begin
                frz_done = 1'b1;
                sx = x_c; sy = y_c; shs = hs_c; svs = vs_c;
                en_c = 1'b0;
                fz_bad = 0;
                for (int k = 0; k < 1000; k++) begin
                    tick();
                    c++;
                    if (x_c !== sx || y_c !== sy || hs_c !== shs || vs_c !== svs ||
                        pix_ce_c || sof_c || eol_c) fz_bad++;
                end
                en_c = 1'b1;
                chk("c_pause_x_nonzero", 32'(sx != 4'd0), 1);
                chk("c_pause_frozen", fz_bad, 0);
            end
        end
        chk("c_sof_count", sofc, 5);

        // C: one-clk reset mid-frame, held together with en=0
        n = 0;
        while (y_c != 4'd3 && n < 600) begin
            tick();
            n++;
        end
        for (int k = 0; k < 10; k++) tick();
        chk("c_pre_rst_y", 32'(y_c), 3);
        rst_c = 1'b0;
        en_c  = 1'b0;
        tick();
        chk("c_rst_x",      32'(x_c), 0);
        chk("c_rst_y",      32'(y_c), 0);
        chk("c_rst_de",     32'(de_c), 1);
        chk("c_rst_hsync",  32'(hs_c), 1);
        chk("c_rst_vsync",  32'(vs_c), 1);
        chk("c_rst_fc",     32'(fc_c), 0);
        chk("c_rst_pix_ce", 32'(pix_ce_c), 0);
        chk("c_rst_eol",    32'(eol_c), 0);
        rst_c = 1'b1;
        en_c  = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!pix_ce_c && n < 10);
        chk("c_first_ce_clk", n, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
